debounced_updown_counter: RTL and testbench
===========================================

Name: debounced_updown_counter

Overview:
- Parametrised successor to the single-switch debounce → pulse → counter chain.
- Integrates a shared debounce ticker, per-channel 2-FF synchronisers and debounce FSMs for separate up/down buttons, edge-pulse generation and a WIDTH-bit up/down counter with load, wrap/saturate mode and overflow/underflow flags.
- Its count output drives the display controller directly.

Parameters:
- WIDTH, 32, counter width in bits (≥2).
- DB_TICK_DIV, 1000000, clk cycles per debounce sample tick (≥2).
- DB_SAMPLES, 4, consecutive agreeing samples needed to change a debounced level (1..15).
- STEP, 1, increment/decrement amount per accepted press (1..2^WIDTH-1).
- SATURATE, 0, 0 = wrap modulo 2^WIDTH; 1 = clamp at 0 and 2^WIDTH-1.

Ports:
- clk, input, 1, system clock; all state on rising edge.
- reset, input, 1, asynchronous active-low reset; clears all state immediately.
- en, input, 1, count enable; 0 blocks counting only (debounce keeps running).
- btn_up, input, 1, raw asynchronous up button.
- btn_dn, input, 1, raw asynchronous down button.
- load, input, 1, synchronous load strobe.
- load_val, input, WIDTH, value loaded when load=1.
- count, output, WIDTH, current count.
- db_up, output, 1, debounced level of btn_up.
- db_dn, output, 1, debounced level of btn_dn.
- ovf, output, 1, one-cycle pulse on up-step wrap or clamp.
- udf, output, 1, one-cycle pulse on down-step wrap or clamp.

Behaviour:
- Reset (reset=0, async): ticker=0; synchronisers=0; both FSMs in LOW with sample counter 0; count=0; db_up=db_dn=ovf=udf=0.
- Ticker: counts 0..DB_TICK_DIV-1 and wraps. tick=1 for exactly one cycle when the counter equals DB_TICK_DIV-1. First tick occurs DB_TICK_DIV cycles after reset release.
- Synchroniser: 2-FF per button; FSMs use the second-stage output s.
- Debounce FSM, per channel, with states LOW, WAIT_HI, HIGH, WAIT_LO and sample counter n. All transitions occur only on tick cycles.
  - LOW: s=1 → WAIT_HI, n=1 (if DB_SAMPLES=1 → HIGH directly).
  - WAIT_HI: s=1 → n+1; reaching n=DB_SAMPLES → HIGH. s=0 → LOW, n=0.
  - HIGH and WAIT_LO: mirror of the above with s=0.
  - db level = 1 in HIGH and WAIT_LO, 0 otherwise; registered.
- Edge pulse: p = db & ~db_q (db_q is db delayed one clk). One cycle wide, asserted the clk after db rises.
- Counter update, registered, priority highest first:
  1. load=1 → count=load_val, no flags; load ignores en.
  2. en=0 → hold.
  3. p_up & p_dn in the same cycle → hold, no flags.
  4. p_up only → count+STEP.
  5. p_dn only → count−STEP.
- Arithmetic is computed in WIDTH+1 bits.
  - Up step: carry out → ovf=1. SATURATE=0 gives result mod 2^WIDTH; SATURATE=1 gives 2^WIDTH-1.
  - Down step: borrow → udf=1. SATURATE=0 wraps; SATURATE=1 gives 0.
  - With SATURATE=1, stepping up at the maximum or down at 0 still pulses ovf/udf and holds the value.
- Latency: from a raw edge stable at clk, count changes after 2 (sync) + wait to DB_SAMPLES ticks + 1 (db reg) + 1 (pulse) + 1 (count) clks.
- Reset asserted mid-debounce or mid-hold discards all progress. A button held through reset release is re-debounced and produces one press.

Optional Feature:
- Macro DUC_AUTOREPEAT_EN.
- Defined:
  - Adds parameter REPEAT_TICKS (default 50).
  - While a channel stays in HIGH, a per-channel tick counter generates an extra one-cycle pulse after REPEAT_TICKS ticks, then every REPEAT_TICKS/4 ticks (minimum 1).
  - The counter resets on leaving HIGH.
  - Repeat pulses obey the same priority and simultaneous-cancel rules.
- Undefined: exactly one pulse per debounced press; no repeat logic is synthesised.

Test Plan:
- Config for all scenarios: WIDTH=8, DB_TICK_DIV=4, DB_SAMPLES=3, STEP=1, SATURATE=0, en=1.
- Clean press: hold btn_up=1 for 40 clks, then release → db_up rises after 3 consecutive high ticks; count goes 0→1 exactly once; ovf=0.
- Bounce: toggle btn_up every 3 clks for 30 clks, then hold high → no count change during the bounce; a single increment once stable for 3 ticks.
- Wrap and saturate:
  - load_val=8'hFF, load=1 for 1 clk, then one up press → count=8'h00, ovf pulses 1 cycle.
  - Repeat with SATURATE=1 → count stays 8'hFF, ovf pulses.
- Underflow: count=0, one down press → SATURATE=0 gives 8'hFF and udf=1; SATURATE=1 gives 0 and udf=1.
- Simultaneous and priority:
  - Identical up/down press stimulus → count unchanged, no flags.
  - load=1 in the same cycle as p_up → count=load_val.
  - en=0 during a press → count unchanged, db_up still toggles.
- Async reset: assert reset=0 mid-WAIT_HI, between clock edges, with count=5 → count, db_*, ovf and udf read 0 before the next clk edge. After release with the button still held → exactly one increment.

Source files
------------

// File: rtl/debounced_updown_counter.sv
// Up/down press counter: shared debounce ticker, per-button sync + debounce FSM + press pulse, WIDTH-bit counter.
// Optional hold-to-repeat is enabled by defining DUC_AUTOREPEAT_EN (adds parameter REPEAT_TICKS).

// state   | meaning
// LOW     | debounced level 0, synced input agrees
// WAIT_HI | level 0, counting consecutive high samples
// HIGH    | debounced level 1, synced input agrees
// WAIT_LO | level 1, counting consecutive low samples
module duc_db_channel #(
  parameter int DB_SAMPLES = 4
`ifdef DUC_AUTOREPEAT_EN
  , parameter int REPEAT_TICKS = 50
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic btn,
  output logic db,
  output logic press
);

  typedef enum logic [1:0] {LOW, WAIT_HI, HIGH, WAIT_LO} state_t;

  localparam logic [3:0] SAMPLES = 4'(DB_SAMPLES);

  logic   sync1;
  logic   s;
  state_t state;
  logic   [3:0] n;
  logic   db_q;
  logic   rep;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= btn;
      s     <= sync1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= LOW;
      n     <= '0;
    end else if (tick) begin
      case (state)
        LOW: begin
          if (s) begin
            if (SAMPLES == 4'd1) begin
              state <= HIGH;
              n     <= '0;
            end else begin
              state <= WAIT_HI;
              n     <= 4'd1;
            end
          end
        end
        WAIT_HI: begin
          if (!s) begin
            state <= LOW;
            n     <= '0;
          end else if (n + 4'd1 == SAMPLES) begin
            state <= HIGH;
            n     <= '0;
          end else begin
            n <= n + 4'd1;
          end
        end
        HIGH: begin
          if (!s) begin
            if (SAMPLES == 4'd1) begin
              state <= LOW;
              n     <= '0;
            end else begin
              state <= WAIT_LO;
              n     <= 4'd1;
            end
          end
        end
        WAIT_LO: begin
          if (s) begin
            state <= HIGH;
            n     <= '0;
          end else if (n + 4'd1 == SAMPLES) begin
            state <= LOW;
            n     <= '0;
          end else begin
            n <= n + 4'd1;
          end
        end
        default: begin
          state <= LOW;
          n     <= '0;
        end
      endcase
    end
  end

`ifdef DUC_AUTOREPEAT_EN
  localparam int RW        = (REPEAT_TICKS < 2) ? 1 : $clog2(REPEAT_TICKS + 1);
  localparam int REP_NEXT  = (REPEAT_TICKS / 4 < 1) ? 1 : REPEAT_TICKS / 4;
  localparam logic [RW-1:0] REP_FIRST_V = RW'(REPEAT_TICKS);
  localparam logic [RW-1:0] REP_NEXT_V  = RW'(REP_NEXT);

  logic [RW-1:0] rcnt;
  logic          rfirst;

  // Tick counter only runs while the debounced level is solidly HIGH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rcnt   <= '0;
      rfirst <= 1'b1;
      rep    <= 1'b0;
    end else if (state != HIGH) begin
      rcnt   <= '0;
      rfirst <= 1'b1;
      rep    <= 1'b0;
    end else begin
      rep <= 1'b0;
      if (tick) begin
        if (rcnt + RW'(1) == (rfirst ? REP_FIRST_V : REP_NEXT_V)) begin
          rep    <= 1'b1;
          rcnt   <= '0;
          rfirst <= 1'b0;
        end else begin
          rcnt <= rcnt + RW'(1);
        end
      end
    end
  end
`else
  assign rep = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      db    <= 1'b0;
      db_q  <= 1'b0;
      press <= 1'b0;
    end else begin
      db    <= (state == HIGH) || (state == WAIT_LO);
      db_q  <= db;
      press <= (db & ~db_q) | rep;
    end
  end

endmodule

module debounced_updown_counter #(
  parameter int              WIDTH       = 32,
  parameter int              DB_TICK_DIV = 1000000,
  parameter int              DB_SAMPLES  = 4,
  parameter longint unsigned STEP        = 1,
  parameter int              SATURATE    = 0
`ifdef DUC_AUTOREPEAT_EN
  , parameter int            REPEAT_TICKS = 50
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             btn_up,
  input  logic             btn_dn,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             db_up,
  output logic             db_dn,
  output logic             ovf,
  output logic             udf
);

  localparam int TW  = $clog2(DB_TICK_DIV);
  localparam int WP1 = WIDTH + 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DB_TICK_DIV - 1);
  localparam logic [WIDTH:0] STEP_X   = WP1'(STEP);

  logic [TW-1:0]  tcnt;
  logic           tick;
  logic           p_up;
  logic           p_dn;
  logic [WIDTH:0] up_sum;
  logic [WIDTH:0] dn_diff;

  assign tick = (tcnt == TICK_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) tcnt <= '0;
    else        tcnt <= tick ? '0 : tcnt + TW'(1);
  end

  duc_db_channel #(
    .DB_SAMPLES   (DB_SAMPLES)
`ifdef DUC_AUTOREPEAT_EN
    , .REPEAT_TICKS (REPEAT_TICKS)
`endif
  ) u_ch_up (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .btn   (btn_up),
    .db    (db_up),
    .press (p_up)
  );

  duc_db_channel #(
    .DB_SAMPLES   (DB_SAMPLES)
`ifdef DUC_AUTOREPEAT_EN
    , .REPEAT_TICKS (REPEAT_TICKS)
`endif
  ) u_ch_dn (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .btn   (btn_dn),
    .db    (db_dn),
    .press (p_dn)
  );

  // One extra bit exposes the carry/borrow of a step.
  assign up_sum  = {1'b0, count} + STEP_X;
  assign dn_diff = {1'b0, count} - STEP_X;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      ovf <= 1'b0;
      udf <= 1'b0;
      if (load) begin
        count <= load_val;
      end else if (en && (p_up != p_dn)) begin
        if (p_up) begin
          if (up_sum[WIDTH]) begin
            ovf   <= 1'b1;
            count <= (SATURATE != 0) ? {WIDTH{1'b1}} : up_sum[WIDTH-1:0];
          end else begin
            count <= up_sum[WIDTH-1:0];
          end
        end else begin
          if (dn_diff[WIDTH]) begin
            udf   <= 1'b1;
            count <= (SATURATE != 0) ? {WIDTH{1'b0}} : dn_diff[WIDTH-1:0];
          end else begin
            count <= dn_diff[WIDTH-1:0];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_debounced_updown_counter.sv
// Scoreboard bench: a wrap-mode and a saturate-mode counter share stimulus; a press-level model predicts events.
module tb_debounced_updown_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_dn = 1'b0;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'h00;

  logic [7:0] count_w, count_s;
  logic       db_up_w, db_dn_w, ovf_w, udf_w;
  logic       db_up_s, db_dn_s, ovf_s, udf_s;

  always #5 clk = ~clk;

  debounced_updown_counter #(.WIDTH(8), .DB_TICK_DIV(4), .DB_SAMPLES(3), .STEP(1), .SATURATE(0)) dut_w (
    .clk(clk), .reset(reset), .en(en), .btn_up(btn_up), .btn_dn(btn_dn), .load(load),
    .load_val(load_val), .count(count_w), .db_up(db_up_w), .db_dn(db_dn_w), .ovf(ovf_w), .udf(udf_w));

  debounced_updown_counter #(.WIDTH(8), .DB_TICK_DIV(4), .DB_SAMPLES(3), .STEP(1), .SATURATE(1)) dut_s (
    .clk(clk), .reset(reset), .en(en), .btn_up(btn_up), .btn_dn(btn_dn), .load(load),
    .load_val(load_val), .count(count_s), .db_up(db_up_s), .db_dn(db_dn_s), .ovf(ovf_s), .udf(udf_s));

  typedef struct packed {
    logic [7:0] cnt;
    logic       ovf;
    logic       udf;
  } exp_t;

  exp_t q_w[$];
  exp_t q_s[$];
  int   model_cnt[2];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push(input int i, input exp_t e);
    if (i == 0) q_w.push_back(e);
    else        q_s.push_back(e);
  endtask

  // Accepted press: +/-1, wrap modulo 256 (instance 0) or clamp (instance 1); flag on leaving 0..255.
  task automatic model_step(input bit up);
    for (int i = 0; i < 2; i++) begin
      int   v;
      bit   fl;
      exp_t e;
      v  = up ? model_cnt[i] + 1 : model_cnt[i] - 1;
      fl = (v > 255) || (v < 0);
      if (fl) begin
        if (i == 1) v = up ? 255 : 0;
        else        v = (v + 256) % 256;
      end
      model_cnt[i] = v;
      e.cnt = 8'(v);
      e.ovf = up && fl;
      e.udf = !up && fl;
      push(i, e);
    end
  endtask

  task automatic model_set(input int val);
    for (int i = 0; i < 2; i++) begin
      exp_t e;
      if (model_cnt[i] != val) begin
        e.cnt = 8'(val);
        e.ovf = 1'b0;
        e.udf = 1'b0;
        push(i, e);
      end
      model_cnt[i] = val;
    end
  endtask

  task automatic observe(input int i, input logic [7:0] c, input logic o, input logic u);
    exp_t e;
    checks++;
    if ((i == 0 && q_w.size() == 0) || (i == 1 && q_s.size() == 0)) begin
      failures++;
      $display("FAIL unexpected_event[%0d]: got count=%0h ovf=%0b udf=%0b, expected no event", i, c, o, u);
      return;
    end
    e = (i == 0) ? q_w.pop_front() : q_s.pop_front();
    if (c !== e.cnt || o !== e.ovf || u !== e.udf) begin
      failures++;
      $display("FAIL event[%0d]: got count=%0h ovf=%0b udf=%0b expected count=%0h ovf=%0b udf=%0b",
               i, c, o, u, e.cnt, e.ovf, e.udf);
    end
  endtask

  // Monitor: any count change or flag pulse is an output event to be matched.
  initial begin
    logic [7:0] prev_w;
    logic [7:0] prev_s;
    prev_w = 8'h00;
    prev_s = 8'h00;
    forever begin
      @(negedge clk);
      if (count_w !== prev_w || ovf_w || udf_w) observe(0, count_w, ovf_w, udf_w);
      if (count_s !== prev_s || ovf_s || udf_s) observe(1, count_s, ovf_s, udf_s);
      prev_w = count_w;
      prev_s = count_s;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit up, input bit dn, input int hold);
    @(negedge clk);
    btn_up = up;
    btn_dn = dn;
    wait_clks(hold);
    btn_up = 1'b0;
    btn_dn = 1'b0;
    wait_clks(35 + $urandom_range(0, 10));
  endtask

  task automatic load_op(input logic [7:0] val);
    @(negedge clk);
    load     = 1'b1;
    load_val = val;
    model_set(int'(val));
    @(negedge clk);
    load = 1'b0;
    wait_clks(5);
  endtask

  task automatic bounce_up();
    int r;
    r = $urandom_range(1, 3);
    @(negedge clk);
    btn_up = 1'b1;
    wait_clks(r);
    for (int k = r; k < 30; k += 3) begin
      btn_up = ~btn_up;
      wait_clks(3);
    end
    chk("bounce_hold_w", int'(count_w), model_cnt[0]);
    chk("bounce_hold_s", int'(count_s), model_cnt[1]);
    btn_up = 1'b1;
    model_step(1'b1);
    wait_clks(35);
    btn_up = 1'b0;
    wait_clks(40);
  endtask

  initial begin
    model_cnt[0] = 0;
    model_cnt[1] = 0;
    #1 reset = 1'b0;
    #20;
    chk("reset_count_w", int'(count_w), 0);
    chk("reset_count_s", int'(count_s), 0);
    chk("reset_db", int'({db_up_w, db_dn_w, db_up_s, db_dn_s}), 0);
    chk("reset_flags", int'({ovf_w, udf_w, ovf_s, udf_s}), 0);
    @(negedge clk);
    reset = 1'b1;
    wait_clks(5);

    // clean press
    model_step(1'b1);
    btn_up = 1'b1;
    wait_clks(9);
    chk("db_up_early", int'(db_up_w), 0);
    wait_clks(21);
    chk("db_up_held", int'(db_up_w), 1);
    chk("clean_count", int'(count_w), 1);
    wait_clks(10);
    btn_up = 1'b0;
    wait_clks(40);
    chk("db_up_released", int'(db_up_w), 0);

    bounce_up();

    // wrap / saturate at top, then bottom
    load_op(8'hFF);
    model_step(1'b1);
    press(1'b1, 1'b0, 40);
    load_op(8'h00);
    model_step(1'b0);
    press(1'b0, 1'b1, 40);

    // simultaneous presses cancel
    load_op(8'h40);
    press(1'b1, 1'b1, 40);
    chk("simul_count", int'(count_w), 8'h40);

    // load held across the up pulse wins
    @(negedge clk);
    load     = 1'b1;
    load_val = 8'h77;
    model_set(8'h77);
    btn_up = 1'b1;
    wait_clks(40);
    load   = 1'b0;
    btn_up = 1'b0;
    wait_clks(40);

    // en=0 blocks counting but not debouncing
    en     = 1'b0;
    btn_up = 1'b1;
    wait_clks(30);
    chk("en0_db_up_high", int'(db_up_w), 1);
    btn_up = 1'b0;
    wait_clks(30);
    chk("en0_db_up_low", int'(db_up_w), 0);
    en = 1'b1;
    wait_clks(10);

    // randomized operations
    for (int it = 0; it < 30; it++) begin
      int op;
      int hold;
      op   = $urandom_range(0, 5);
      hold = $urandom_range(30, 45);
      case (op)
        0: begin model_step(1'b1); press(1'b1, 1'b0, hold); end
        1: begin model_step(1'b0); press(1'b0, 1'b1, hold); end
        2: press(1'b1, 1'b1, hold);
        3: load_op(8'($urandom_range(0, 255)));
        4: begin
          en = 1'b0;
          if ($urandom_range(0, 1) == 1) press(1'b1, 1'b0, hold);
          else                           press(1'b0, 1'b1, hold);
          en = 1'b1;
        end
        default: bounce_up();
      endcase
    end

    // async reset mid-WAIT_HI, button held through release
    load_op(8'h05);
    @(negedge clk);
    btn_up = 1'b1;
    wait_clks(6);
    @(posedge clk);
    #2;
    model_set(0);
    reset = 1'b0;
    #1;
    chk("async_count_w", int'(count_w), 0);
    chk("async_count_s", int'(count_s), 0);
    chk("async_db", int'({db_up_w, db_dn_w, db_up_s, db_dn_s}), 0);
    chk("async_flags", int'({ovf_w, udf_w, ovf_s, udf_s}), 0);
    wait_clks(3);
    reset = 1'b1;
    model_step(1'b1);
    wait_clks(40);
    btn_up = 1'b0;
    wait_clks(40);
    chk("post_reset_count", int'(count_w), 1);

    wait_clks(20);
    chk("pending_w", q_w.size(), 0);
    chk("pending_s", q_s.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
